// File: rtl/aes_sub_bytes.sv
// aes_sub_bytes: iterative AES SubBytes, one 32-bit column per clock through four S-boxes
module aes_sub_bytes (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [127:0] state_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] state_o
);
  typedef enum logic {IDLE, BUSY} fsm_e;
  fsm_e         fsm_q, fsm_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d, res_q, res_d;
  logic         done_q, done_d;
  logic [31:0]  col_in, col_sub;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // inverse as x^254 (0 maps to 0), then the Rijndael affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  // column c sits at bit offset 32*(3-c), i.e. {~c, 5'b0}
  assign col_in = work_q[{~col_q, 5'd0} +: 32];
  for (genvar r = 0; r < 4; r++) begin : g_sbox
    assign col_sub[8*r +: 8] = sbox(col_in[8*r +: 8]);
  end
  always_comb begin
    fsm_d  = fsm_q;
    col_d  = col_q;
    work_d = work_q;
    res_d  = res_q;
    done_d = 1'b0;
    if (fsm_q == IDLE) begin
      if (en_i) begin
        work_d = state_i;
        col_d  = 2'd0;
        fsm_d  = BUSY;
      end
    end else begin
      work_d[{~col_q, 5'd0} +: 32] = col_sub;
      col_d = col_q + 2'd1;
      if (col_q == 2'd3) begin
        res_d  = work_d;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      col_q  <= 2'd0;
      work_q <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      col_q  <= col_d;
      work_q <= work_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end
  assign busy_o  = (fsm_q == BUSY);
  assign done_o  = done_q;
  assign state_o = res_q;
endmodule

// File: tb/tb_aes_sub_bytes.sv
// tb_aes_sub_bytes: directed + random checks of aes_sub_bytes against a table-driven SubBytes model
module tb_aes_sub_bytes;
  logic         clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_i = 1'b0;
  logic [127:0] state_i = '0;
  logic         busy_o, done_o;
  logic [127:0] state_o;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] prev_res = '0;
  logic [127:0] sb_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  aes_sub_bytes dut (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .state_i(state_i),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o));
  always #5 clk_i = ~clk_i;
  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = s[8*i +: 8];
      o[8*i +: 8] = sb_rows[b[7:4]][8*(15 - b[3:0]) +: 8];
    end
    return o;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // one full operation; noisy toggles en_i and state_i during BUSY
  task automatic do_op(input string tag, input logic [127:0] vec, input bit noisy);
    logic [127:0] exp;
    exp = ref_sub(vec);
    @(negedge clk_i);
    state_i = vec;
    en_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, {127'd0, busy_o}, 128'd1);
      chk({tag, " no_done"}, {127'd0, done_o}, 128'd0);
      chk({tag, " hold"}, state_o, prev_res);
      if (noisy) begin
        en_i = 1'($urandom);
        state_i = rnd128();
      end
      @(negedge clk_i);
    end
    en_i = 1'b0;
    chk({tag, " done"}, {127'd0, done_o}, 128'd1);
    chk({tag, " idle"}, {127'd0, busy_o}, 128'd0);
    chk({tag, " result"}, state_o, exp);
    prev_res = exp;
    @(negedge clk_i);
    chk({tag, " single_pulse"}, {127'd0, done_o}, 128'd0);
    chk({tag, " stays_idle"}, {127'd0, busy_o}, 128'd0);
  endtask
  initial begin
    logic [127:0] vq [4];
    int idx, last, cyc;
    #1;
    chk("reset state_o", state_o, 128'd0);
    chk("reset done", {127'd0, done_o}, 128'd0);
    chk("reset busy", {127'd0, busy_o}, 128'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    do_op("fips", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
    chk("fips const", prev_res, 128'hd42711aee0bf98f1b8b45de51e415230);
    do_op("zero", 128'd0, 1'b0);
    chk("zero const", state_o, {16{8'h63}});
    do_op("ff", {16{8'hff}}, 1'b0);
    chk("ff const", state_o, {16{8'h16}});
    do_op("53", {16{8'h53}}, 1'b0);
    chk("53 const", state_o, {16{8'hed}});
    do_op("noisy", rnd128(), 1'b1);
    for (int t = 0; t < 6; t++) do_op("rand", rnd128(), 1'b0);
    // back-to-back with en_i held high
    for (int i = 0; i < 4; i++) vq[i] = rnd128();
    @(negedge clk_i);
    state_i = vq[0];
    en_i = 1'b1;
    idx = 0;
    last = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (done_o) begin
        chk("b2b result", state_o, ref_sub(vq[idx]));
        chk("b2b spacing", 128'(cyc - last), (idx == 0) ? 128'd5 : 128'd5);
        last = cyc;
        idx++;
        if (idx < 4) state_i = vq[idx];
      end
    end
    chk("b2b count", 128'(idx), 128'd4);
    en_i = 1'b0;
    prev_res = ref_sub(vq[3]);
    repeat (6) @(negedge clk_i);
    // abort: async reset two cycles after start
    @(negedge clk_i);
    state_i = rnd128();
    en_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    chk("abort state_o", state_o, 128'd0);
    chk("abort done", {127'd0, done_o}, 128'd0);
    chk("abort busy", {127'd0, busy_o}, 128'd0);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("abort no_done", {127'd0, done_o}, 128'd0);
      chk("abort zero", state_o, 128'd0);
    end
    prev_res = '0;
    do_op("after_abort", rnd128(), 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
